wb_monitor: RTL and testbench
=============================

# wb_monitor

Parametrised, synthesizable writeback monitor for the pipelined RISC-V core. It snoops the MEM/WB register-file write port and captures the values written to up to NUM_WATCH selected architectural registers. It raises `done` once every enabled register has been written, or `timeout` after a cycle budget is exhausted. A small trace FIFO records every register write and can be drained over a valid/ready handshake. It replaces the ad-hoc "stop when x4 becomes defined" bench logic, and it also works on FPGA.

## Interface
- `NUM_WATCH`, 4: number of watch channels (1–8).
- `XLEN`, 32: data/PC width.
- `TIMEOUT_CYCLES`, 1024: RUN cycles before timeout (≥2).
- `TRACE_DEPTH`, 8: trace FIFO entries (power of two, ≥2).

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; clears and (re)arms the monitor.
- `wb_we` in 1: register-file write enable (mem_wb RegWrite).
- `wb_rd` in 5: destination register.
- `wb_data` in XLEN: writeback data.
- `wb_pc` in XLEN: PC of the retiring instruction.
- `watch_idx` in NUM_WATCH*5: register index per channel; channel i uses bits [5i+4:5i].
- `watch_mask` in NUM_WATCH: channels required for `done`.
- `watch_val` out NUM_WATCH*XLEN: last captured value per channel.
- `watch_valid` out NUM_WATCH: channel has been written since `start`.
- `busy` out 1: state is RUN.
- `done` out 1: state is DONE.
- `timeout` out 1: state is TIMEOUT.
- `cycle_count` out 32: RUN cycles elapsed.
- `trace_valid` out 1: FIFO non-empty.
- `trace_ready` in 1: consumer pops the head when high together with `trace_valid`.
- `trace_rd` out 5: head entry register index.
- `trace_data` out XLEN: head entry data.
- `trace_pc` out XLEN: head entry PC.
- `trace_overflow` out 1: sticky flag; a write was dropped because the FIFO was full.

## Operation
- **States:**
  - IDLE → RUN on `start`.
  - RUN → DONE when the done condition holds.
  - RUN → TIMEOUT when `cycle_count` == TIMEOUT_CYCLES-1 and the done condition is false.
  - DONE and TIMEOUT hold until `start`.
  - `start` in any state (including RUN) enters RUN and clears: `watch_valid`, `watch_val`, `cycle_count`, FIFO contents and `trace_overflow`.
- **Qualifying write:** `wb_we`=1, `wb_rd`≠0, state RUN, and no `start` in the same cycle. Writes to x0 are ignored everywhere.
- **Channel capture:** every channel whose `watch_idx` equals `wb_rd` captures `wb_data` and sets its `watch_valid` bit.
  - Duplicate indices across channels capture identically.
  - A later write overwrites the earlier value.
- **Done condition:** `watch_mask`≠0 and (`watch_valid` & `watch_mask`) == `watch_mask`, evaluated on registered `watch_valid`.
  - With `watch_mask`=0 the monitor never reaches DONE and ends in TIMEOUT.
  - If done and timeout become true in the same cycle, DONE wins.
- **cycle_count:** increments every RUN cycle, saturates at 2^32-1, and is frozen in DONE/TIMEOUT.
- **Trace FIFO:** each qualifying write pushes {rd, data, pc}.
  - Full and no pop: entry dropped, `trace_overflow` set.
  - Full with simultaneous pop: push succeeds, no overflow.
  - Pops are allowed in any state, so DONE/TIMEOUT contents remain drainable.
  - Output order is FIFO; head fields are valid only while `trace_valid`=1.

## Timing
- **Reset values:** state IDLE, all outputs 0.
- **Capture latency:** a write sampled at edge N is visible on `watch_val`/`watch_valid` after edge N.
- **Done latency:** `done` rises one edge later, at N+1.
- **Timeout timing:** `start` at edge S gives `busy` from S; with no done, `timeout` rises after edge S+TIMEOUT_CYCLES, and `cycle_count` then reads TIMEOUT_CYCLES-1.
- **Trace latency:** a pushed entry appears at the head one cycle after the push edge when the FIFO was empty.
- **Pop timing:** a pop occurs on an edge where `trace_valid` & `trace_ready`; the next entry is presented after that edge.
- **Reset mid-operation:** asynchronous assertion immediately forces all outputs to 0 and discards FIFO contents.

## Configuration
- **`WB_MONITOR_PC_TRACE_EN` defined:** FIFO entries store `wb_pc`, and `trace_pc` outputs the head entry's PC.
- **Not defined:** PC storage is omitted from the FIFO and `trace_pc` is constant 0. All other behaviour is identical.

## Test plan
- **Basic done:** mask=4'b1111, idx={4,3,2,1}, start, then writes x1=5, x2=10, x3=15, x4=20 on consecutive cycles → `watch_val`={20,15,10,5}, `done` one cycle after the x4 write, `cycle_count` frozen.
- **x0 and start-cycle filtering:** write x0=7 with idx0=0, then write x1=9 in the same cycle as `start` → `watch_valid`=0, FIFO empty.
- **Timeout:** TIMEOUT_CYCLES=16, mask=0, start → `timeout`=1 after 16 edges, `cycle_count`=15, `done`=0.
- **FIFO overflow:** TRACE_DEPTH=8, trace_ready=0, 10 writes → 8 entries drained in order, `trace_overflow`=1. Repeat with a simultaneous pop on the 9th write → `trace_overflow`=0.
- **Restart:** `start` in DONE → `watch_valid`, `cycle_count`, FIFO and `trace_overflow` cleared, `busy`=1.
- **Async reset:** reset low mid-RUN with 3 trace entries → all outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/wb_monitor.sv
// wb_monitor: writeback snooper for the pipelined RISC-V core.
// Watches the MEM/WB register-file write port, captures the values written
// to up to NUM_WATCH selected registers, and reports done/timeout. Every
// qualifying write is also recorded in a small trace FIFO that can be drained
// over a valid/ready handshake.
//
// Build option: define WB_MONITOR_PC_TRACE_EN to store wb_pc in each trace
// entry and present it on trace_pc. Without it, trace_pc is tied to 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, waiting for start
// RUN      | capturing writes, counting cycles
// DONE     | every masked channel written; held until start
// TIMEOUT  | cycle budget exhausted; held until start
module wb_monitor #(
  parameter int NUM_WATCH      = 4,
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TRACE_DEPTH    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      wb_we,
  input  logic [4:0]                wb_rd,
  input  logic [XLEN-1:0]           wb_data,
  input  logic [XLEN-1:0]           wb_pc,
  input  logic [NUM_WATCH*5-1:0]    watch_idx,
  input  logic [NUM_WATCH-1:0]      watch_mask,
  output logic [NUM_WATCH*XLEN-1:0] watch_val,
  output logic [NUM_WATCH-1:0]      watch_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  output logic [31:0]               cycle_count,
  output logic                      trace_valid,
  input  logic                      trace_ready,
  output logic [4:0]                trace_rd,
  output logic [XLEN-1:0]           trace_data,
  output logic [XLEN-1:0]           trace_pc,
  output logic                      trace_overflow
);

  localparam int          AW      = $clog2(TRACE_DEPTH);
  localparam logic [31:0] TC_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [31:0]          cycle_count_q, cycle_count_d;
  logic [XLEN-1:0]      watch_val_q   [NUM_WATCH];
  logic [XLEN-1:0]      watch_val_d   [NUM_WATCH];
  logic [NUM_WATCH-1:0] watch_valid_q, watch_valid_d;

  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic                 overflow_q, overflow_d;
  logic [4:0]           mem_rd_q   [TRACE_DEPTH];
  logic [XLEN-1:0]      mem_data_q [TRACE_DEPTH];
  logic [AW-1:0]        waddr, raddr;

  logic wr_qual;
  logic done_cond;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic drop;

  // A start in the same cycle wins over the write: the monitor is being re-armed.
  assign wr_qual   = wb_we && (wb_rd != 5'd0) && (state_q == ST_RUN) && !start;
  assign done_cond = (|watch_mask) && ((watch_valid_q & watch_mask) == watch_mask);

  assign waddr      = wr_ptr_q[AW-1:0];
  assign raddr      = rd_ptr_q[AW-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (waddr == raddr);
  assign pop        = !fifo_empty && trace_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push       = wr_qual && (!fifo_full || pop);
  assign drop       = wr_qual && fifo_full && !pop;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; done takes priority over timeout on the same cycle
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (done_cond)                    state_d = ST_DONE;
          else if (cycle_count_q == TC_LAST) state_d = ST_TIMEOUT;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      ST_RUN:     busy    = 1'b1;
      ST_DONE:    done    = 1'b1;
      ST_TIMEOUT: timeout = 1'b1;
      default:    busy    = 1'b0;
    endcase
  end

  // Cycle counter: counts RUN cycles that stay in RUN, so it freezes on exit
  always_comb begin
    cycle_count_d = cycle_count_q;
    if (start) begin
      cycle_count_d = '0;
    end else if ((state_q == ST_RUN) && (state_d == ST_RUN) && (cycle_count_q != '1)) begin
      cycle_count_d = cycle_count_q + 32'd1;
    end
  end

  // Channel capture: every channel matching wb_rd takes the data
  always_comb begin
    watch_val_d   = watch_val_q;
    watch_valid_d = watch_valid_q;
    if (start) begin
      for (int i = 0; i < NUM_WATCH; i++) watch_val_d[i] = '0;
      watch_valid_d = '0;
    end else if (wr_qual) begin
      for (int i = 0; i < NUM_WATCH; i++) begin
        if (watch_idx[5*i +: 5] == wb_rd) begin
          watch_val_d[i]   = wb_data;
          watch_valid_d[i] = 1'b1;
        end
      end
    end
  end

  // FIFO pointers and sticky overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (start) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
      if (drop) overflow_d = 1'b1;
    end
  end

  // Counter, capture and FIFO control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count_q <= '0;
      watch_valid_q <= '0;
      for (int i = 0; i < NUM_WATCH; i++) watch_val_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      overflow_q    <= 1'b0;
    end else begin
      cycle_count_q <= cycle_count_d;
      watch_valid_q <= watch_valid_d;
      for (int i = 0; i < NUM_WATCH; i++) watch_val_q[i] <= watch_val_d[i];
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      overflow_q    <= overflow_d;
    end
  end

  // Trace payload storage; no reset needed because reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_q[waddr]   <= wb_rd;
      mem_data_q[waddr] <= wb_data;
    end
  end

  for (genvar g = 0; g < NUM_WATCH; g++) begin : g_watch_out
    assign watch_val[g*XLEN +: XLEN] = watch_val_q[g];
  end

  assign watch_valid    = watch_valid_q;
  assign cycle_count    = cycle_count_q;
  assign trace_valid    = !fifo_empty;
  assign trace_overflow = overflow_q;
  // Head fields read as zero while empty so reset leaves every output at 0.
  assign trace_rd       = fifo_empty ? '0 : mem_rd_q[raddr];
  assign trace_data     = fifo_empty ? '0 : mem_data_q[raddr];

`ifdef WB_MONITOR_PC_TRACE_EN
  logic [XLEN-1:0] mem_pc_q [TRACE_DEPTH];

  // PC storage alongside the trace payload
  always_ff @(posedge clk) begin
    if (push) mem_pc_q[waddr] <= wb_pc;
  end

  assign trace_pc = fifo_empty ? '0 : mem_pc_q[raddr];
`else
  logic unused_pc;
  assign unused_pc = ^wb_pc;
  assign trace_pc  = '0;
`endif

endmodule

// File: tb/tb_wb_monitor.sv
// Self-checking bench for wb_monitor: a table of capture vectors, directed
// multi-cycle sequences (filtering, timeout, overflow, restart, async reset)
// and a randomized phase, all compared every cycle against a queue-based
// behavioural model.
module tb_wb_monitor;

  localparam int NW = 4;
  localparam int XL = 32;
  localparam int TC = 16;
  localparam int TD = 8;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
  localparam int M_TO   = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XL-1:0]   wb_data;
  logic [XL-1:0]   wb_pc;
  logic [NW*5-1:0] watch_idx;
  logic [NW-1:0]   watch_mask;
  logic [NW*XL-1:0] watch_val;
  logic [NW-1:0]   watch_valid;
  logic            busy, done, timeout;
  logic [31:0]     cycle_count;
  logic            trace_valid;
  logic            trace_ready;
  logic [4:0]      trace_rd;
  logic [XL-1:0]   trace_data;
  logic [XL-1:0]   trace_pc;
  logic            trace_overflow;

  wb_monitor #(
    .NUM_WATCH(NW), .XLEN(XL), .TIMEOUT_CYCLES(TC), .TRACE_DEPTH(TD)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
    .watch_idx(watch_idx), .watch_mask(watch_mask),
    .watch_val(watch_val), .watch_valid(watch_valid),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_rd(trace_rd), .trace_data(trace_data), .trace_pc(trace_pc),
    .trace_overflow(trace_overflow)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } tr_t;

  int          m_st;
  logic [31:0] m_val [NW];
  logic [NW-1:0] m_valid;
  logic [31:0] m_cnt;
  logic        m_ovf;
  tr_t         m_fifo[$];

  task automatic model_reset();
    m_st = M_IDLE;
    for (int i = 0; i < NW; i++) m_val[i] = '0;
    m_valid = '0;
    m_cnt   = '0;
    m_ovf   = 1'b0;
    m_fifo.delete();
  endtask

  // Apply one clock edge with the inputs currently driven.
  task automatic model_edge();
    bit  dc, full, pp;
    tr_t e;
    dc   = (watch_mask != 0) && ((m_valid & watch_mask) == watch_mask);
    full = (m_fifo.size() == TD);
    pp   = (m_fifo.size() != 0) && trace_ready;
    if (start) begin
      model_reset();
      m_st = M_RUN;
      return;
    end
    if (pp) e = m_fifo.pop_front();
    if (m_st == M_RUN) begin
      if (wb_we && wb_rd != 0) begin
        for (int i = 0; i < NW; i++)
          if (watch_idx[5*i +: 5] == wb_rd) begin
            m_val[i]   = wb_data;
            m_valid[i] = 1'b1;
          end
        if (!full || pp) begin
          e.rd = wb_rd; e.data = wb_data; e.pc = wb_pc;
          m_fifo.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (dc)                 m_st = M_DONE;
      else if (m_cnt == TC-1) m_st = M_TO;
      else if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic compare_all();
    logic [127:0] ev;
    logic [31:0]  epc;
    ev = '0;
    for (int i = 0; i < NW; i++) ev[i*32 +: 32] = m_val[i];
    check("busy",           128'(busy),           128'(m_st == M_RUN));
    check("done",           128'(done),           128'(m_st == M_DONE));
    check("timeout",        128'(timeout),        128'(m_st == M_TO));
    check("watch_valid",    128'(watch_valid),    128'(m_valid));
    check("watch_val",      watch_val,            ev);
    check("cycle_count",    128'(cycle_count),    128'(m_cnt));
    check("trace_valid",    128'(trace_valid),    128'(m_fifo.size() != 0));
    check("trace_overflow", 128'(trace_overflow), 128'(m_ovf));
    if (m_fifo.size() != 0) begin
`ifdef WB_MONITOR_PC_TRACE_EN
      epc = m_fifo[0].pc;
`else
      epc = '0;
`endif
      check("trace_rd",   128'(trace_rd),   128'(m_fifo[0].rd));
      check("trace_data", 128'(trace_data), 128'(m_fifo[0].data));
      check("trace_pc",   128'(trace_pc),   128'(epc));
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     128'(busy),           128'(0));
    check({tag, "_done"},     128'(done),           128'(0));
    check({tag, "_timeout"},  128'(timeout),        128'(0));
    check({tag, "_wvalid"},   128'(watch_valid),    128'(0));
    check({tag, "_wval"},     watch_val,            128'(0));
    check({tag, "_count"},    128'(cycle_count),    128'(0));
    check({tag, "_tvalid"},   128'(trace_valid),    128'(0));
    check({tag, "_trd"},      128'(trace_rd),       128'(0));
    check({tag, "_tdata"},    128'(trace_data),     128'(0));
    check({tag, "_tpc"},      128'(trace_pc),       128'(0));
    check({tag, "_overflow"}, 128'(trace_overflow), 128'(0));
  endtask

  task automatic idle_inputs();
    start = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0; wb_pc = '0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [3:0]  exp_valid;
    logic        exp_done;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b1, 5'd1, 32'd5,  4'b0001, 1'b0, 32'd1};
    vecs[1] = '{1'b1, 5'd0, 32'd99, 4'b0001, 1'b0, 32'd2};
    vecs[2] = '{1'b1, 5'd2, 32'd10, 4'b0011, 1'b0, 32'd3};
    vecs[3] = '{1'b1, 5'd3, 32'd15, 4'b0111, 1'b0, 32'd4};
    vecs[4] = '{1'b1, 5'd4, 32'd20, 4'b1111, 1'b0, 32'd5};
    vecs[5] = '{1'b0, 5'd0, 32'd0,  4'b1111, 1'b1, 32'd5};
    vecs[6] = '{1'b1, 5'd1, 32'd77, 4'b1111, 1'b1, 32'd5};
    vecs[7] = '{1'b0, 5'd0, 32'd0,  4'b1111, 1'b1, 32'd5};

    idle_inputs();
    trace_ready = 1'b0;
    watch_idx   = '0;
    watch_mask  = '0;
    reset       = 1'b0;
    model_reset();
    #12;
    check_all_zero("por");
    reset = 1'b1;
    tick();

    // Basic done, table driven
    watch_idx  = {5'd4, 5'd3, 5'd2, 5'd1};
    watch_mask = 4'hF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wb_we = vecs[k].we; wb_rd = vecs[k].rd; wb_data = vecs[k].data;
      wb_pc = 32'h100 + 32'(k*4);
      tick();
      check("tbl_valid", 128'(watch_valid), 128'(vecs[k].exp_valid));
      check("tbl_done",  128'(done),        128'(vecs[k].exp_done));
      check("tbl_count", 128'(cycle_count), 128'(vecs[k].exp_cnt));
    end
    idle_inputs();
    check("basic_val", watch_val, {32'd20, 32'd15, 32'd10, 32'd5});

    // Restart from DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_busy",  128'(busy),           128'(1));
    check("restart_valid", 128'(watch_valid),    128'(0));
    check("restart_count", 128'(cycle_count),    128'(0));
    check("restart_fifo",  128'(trace_valid),    128'(0));
    check("restart_ovf",   128'(trace_overflow), 128'(0));

    // x0 write and write coincident with start are both ignored
    watch_idx = {5'd4, 5'd3, 5'd2, 5'd0};
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'd7;
    tick();
    check("x0_valid", 128'(watch_valid), 128'(0));
    check("x0_fifo",  128'(trace_valid), 128'(0));
    watch_idx = {5'd4, 5'd3, 5'd2, 5'd1};
    start = 1'b1; wb_rd = 5'd1; wb_data = 32'd9;
    tick();
    idle_inputs();
    check("stw_valid", 128'(watch_valid), 128'(0));
    check("stw_fifo",  128'(trace_valid), 128'(0));

    // Timeout with empty mask
    watch_mask = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < TC; k++) tick();
    check("to_pre_busy",    128'(busy),    128'(1));
    check("to_pre_timeout", 128'(timeout), 128'(0));
    tick();
    check("to_timeout", 128'(timeout),     128'(1));
    check("to_count",   128'(cycle_count), 128'(TC-1));
    check("to_done",    128'(done),        128'(0));
    tick();
    check("to_frozen",  128'(cycle_count), 128'(TC-1));

    // FIFO overflow: 10 writes into 8 entries, then drain in order
    trace_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wb_we = 1'b1; wb_rd = 5'(k + 1); wb_data = 32'h100 + 32'(k); wb_pc = 32'h1000 + 32'(k*4);
      tick();
    end
    idle_inputs();
    check("ovf_flag", 128'(trace_overflow), 128'(1));
    trace_ready = 1'b1;
    for (int k = 0; k < TD; k++) begin
      check("ovf_drain_valid", 128'(trace_valid), 128'(1));
      check("ovf_drain_rd",    128'(trace_rd),    128'(k + 1));
      check("ovf_drain_data",  128'(trace_data),  128'(32'h100 + 32'(k)));
      tick();
    end
    check("ovf_empty", 128'(trace_valid), 128'(0));

    // Full with a simultaneous pop on the 9th write: no overflow
    trace_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      trace_ready = (k == 8);
      wb_we = 1'b1; wb_rd = 5'(k + 1); wb_data = 32'h200 + 32'(k); wb_pc = 32'h2000 + 32'(k*4);
      tick();
    end
    idle_inputs();
    trace_ready = 1'b0;
    check("popfull_ovf", 128'(trace_overflow), 128'(0));
    trace_ready = 1'b1;
    for (int k = 1; k < 9; k++) begin
      check("popfull_rd",   128'(trace_rd),   128'(k + 1));
      check("popfull_data", 128'(trace_data), 128'(32'h200 + 32'(k)));
      tick();
    end
    check("popfull_empty", 128'(trace_valid), 128'(0));

    // Async reset mid-RUN with 3 trace entries
    trace_ready = 1'b0;
    watch_mask  = 4'hF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wb_we = 1'b1; wb_rd = 5'(k + 1); wb_data = 32'h300 + 32'(k); wb_pc = 32'h3000;
      tick();
    end
    idle_inputs();
    check("ar_pre_fifo", 128'(trace_valid), 128'(1));
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_all_zero("arst");
    #10;
    reset = 1'b1;
    tick();
    check("ar_idle_busy", 128'(busy), 128'(0));

    // Randomized phase against the model
    for (int c = 0; c < 400; c++) begin
      start = (c == 0) || ($urandom_range(0, 29) == 0);
      if (start) begin
        for (int i = 0; i < NW; i++) watch_idx[5*i +: 5] = 5'($urandom_range(0, 7));
        watch_mask = ($urandom_range(0, 3) == 0) ? '0 : 4'($urandom);
      end
      wb_we       = ($urandom_range(0, 2) != 0);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      wb_pc       = $urandom;
      trace_ready = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
